cam_cfg_cmd_sequencer: RTL and testbench

//  Parametrised successor to the camera write-register stage. Accepts register-table writes from the instruction

---
 rtl/cam_cfg_pkg.sv | 24 ++
 rtl/cam_cfg_step_rom.sv | 28 ++
 rtl/cam_cfg_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_cam_cfg_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_cfg_pkg.sv
// Shared types and constants for the camera register-table sequencer.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } state_t;

    localparam logic [7:0] CFG_BASE      = 8'h02;

    localparam logic [7:0] REG_EXPOSURE  = 8'h10;
    localparam logic [7:0] REG_SHUTTER   = 8'h11;
    localparam logic [7:0] REG_CROP_XLO  = 8'h20;
    localparam logic [7:0] REG_CROP_XHI  = 8'h21;
    localparam logic [7:0] REG_CROP_YLO  = 8'h22;
    localparam logic [7:0] REG_CROP_YHI  = 8'h23;

    localparam int CFG_STEPS  = 2;
    localparam int CROP_STEPS = 4;

endpackage

// File: rtl/cam_cfg_step_rom.sv
// Maps (burst kind, step) to the camera register address and the 16-bit table field it carries.
module cam_cfg_step_rom
    import cam_cfg_pkg::*;
(
    input  logic       is_crop,
    input  logic [1:0] step,
    output logic [7:0] i2c_addr,
    output logic [1:0] field_sel
);

    always_comb begin
        i2c_addr  = REG_EXPOSURE;
        field_sel = 2'd0;
        if (is_crop) begin
            field_sel = step;
            case (step)
                2'd0:    i2c_addr = REG_CROP_XLO;
                2'd1:    i2c_addr = REG_CROP_XHI;
                2'd2:    i2c_addr = REG_CROP_YLO;
                default: i2c_addr = REG_CROP_YHI;
            endcase
        end else if (step == 2'd1) begin
            i2c_addr  = REG_SHUTTER;
            field_sel = 2'd1;
        end
    end

endmodule

// File: rtl/cam_cfg_cmd_sequencer.sv
// Expands register-table writes into verified camera I2C write bursts and holds the
// per-camera RGB/compression config, committed only by a clean config burst.
module cam_cfg_cmd_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int  N_CAMS    = 2,
    parameter int  I2C_DW    = 16,
    parameter int  MAX_RETRY = 3,
    parameter int  ACK_TMO   = 1023,
    localparam int CAM_W     = (N_CAMS > 1) ? $clog2(N_CAMS) : 1
) (
    input  logic                sysClk,
    input  logic                rst_n,
    input  logic [7:0]          reg_addr,
    input  logic [127:0]        reg_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [7:0]          cam_i2c_addr,
    output logic [I2C_DW-1:0]   cam_i2c_data,
    output logic                cam_i2c_valid,
    input  logic                cam_i2c_ready,
    input  logic [I2C_DW-1:0]   slave_copy,
    input  logic                slave_copy_valid,
    output logic [CAM_W-1:0]    cam_id,
    output logic [N_CAMS-1:0]   rgb,
    output logic [2*N_CAMS-1:0] compression,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W   = $clog2(ACK_TMO + 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);
    localparam logic [TMO_W-1:0]   TMO_LAST    = TMO_W'(ACK_TMO - 1);

    state_t             state, state_nxt;
    logic               kind_crop_q;
    logic [63:0]        data_q;
    logic [1:0]         step_q;
    logic [RETRY_W-1:0] retry_q;
    logic [TMO_W-1:0]   tmo_q;
    logic               err_q;

    logic               addr_ok, kind_crop_dec;
    logic [CAM_W-1:0]   cam_dec;
    logic [7:0]         rom_addr;
    logic [1:0]         rom_sel;
    logic [15:0]        field;
    logic               accept, last_step, rb_match, rb_fail, retry_done;
    logic               unused_hi;

    // Only the low 64 table bits carry fields for either burst kind.
    assign unused_hi = ^reg_data[127:64];

    always_comb begin
        addr_ok       = 1'b0;
        kind_crop_dec = 1'b0;
        cam_dec       = '0;
        if (reg_addr >= CFG_BASE && reg_addr < CFG_BASE + 8'(N_CAMS)) begin
            addr_ok = 1'b1;
            cam_dec = CAM_W'(reg_addr - CFG_BASE);
        end else if (reg_addr >= CFG_BASE + 8'(N_CAMS) &&
                     reg_addr <  CFG_BASE + 8'(2 * N_CAMS)) begin
            addr_ok       = 1'b1;
            kind_crop_dec = 1'b1;
            cam_dec       = CAM_W'(reg_addr - CFG_BASE - 8'(N_CAMS));
        end
    end

    cam_cfg_step_rom u_step_rom (
        .is_crop   (kind_crop_q),
        .step      (step_q),
        .i2c_addr  (rom_addr),
        .field_sel (rom_sel)
    );

    always_comb begin
        case (rom_sel)
            2'd0:    field = data_q[15:0];
            2'd1:    field = data_q[31:16];
            2'd2:    field = data_q[47:32];
            default: field = data_q[63:48];
        endcase
    end

    assign accept     = in_valid && (state == ST_IDLE);
    assign last_step  = kind_crop_q ? (step_q == 2'(CROP_STEPS - 1))
                                    : (step_q == 2'(CFG_STEPS - 1));
    // A readback in the timeout cycle is judged on its value; the timeout only counts when none arrives.
    assign rb_match   = (state == ST_WAIT) && slave_copy_valid && (slave_copy == cam_i2c_data);
    assign rb_fail    = (state == ST_WAIT) && !rb_match && (slave_copy_valid || tmo_q == TMO_LAST);
    assign retry_done = (retry_q == RETRY_LIMIT);

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = addr_ok ? ST_LOAD : ST_FINISH;
            ST_LOAD:   state_nxt = ST_ISSUE;
            ST_ISSUE:  if (cam_i2c_ready) state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (rb_match)     state_nxt = last_step ? ST_FINISH : ST_LOAD;
                else if (rb_fail) state_nxt = retry_done ? ST_FINISH : ST_ISSUE;
            end
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge sysClk or negedge rst_n) begin
        if (!rst_n) begin
            kind_crop_q  <= 1'b0;
            data_q       <= '0;
            step_q       <= '0;
            retry_q      <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
            cam_id       <= '0;
            cam_i2c_addr <= '0;
            cam_i2c_data <= '0;
            rgb          <= '0;
            compression  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    kind_crop_q <= kind_crop_dec;
                    data_q      <= reg_data[63:0];
                    err_q       <= !addr_ok;
                    step_q      <= '0;
                    retry_q     <= '0;
                    if (addr_ok) cam_id <= cam_dec;
                end
                ST_LOAD: begin
                    cam_i2c_addr <= rom_addr;
                    cam_i2c_data <= I2C_DW'(field);
                end
                ST_ISSUE: if (cam_i2c_ready) tmo_q <= '0;
                ST_WAIT: begin
                    if (tmo_q != TMO_LAST) tmo_q <= tmo_q + TMO_W'(1);
                    if (rb_match) begin
                        step_q  <= step_q + 2'd1;
                        retry_q <= '0;
                    end else if (rb_fail) begin
                        if (retry_done) err_q <= 1'b1;
                        else            retry_q <= retry_q + RETRY_W'(1);
                    end
                end
                ST_FINISH: if (!kind_crop_q && !err_q) begin
                    for (int k = 0; k < N_CAMS; k++) begin
                        if (cam_id == CAM_W'(k)) begin
                            rgb[k]             <= data_q[32];
                            compression[2*k+:2] <= data_q[34:33];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready      = (state == ST_IDLE);
    assign cam_i2c_valid = (state == ST_ISSUE);
    assign busy          = (state != ST_IDLE);
    assign done          = (state == ST_FINISH);
    assign err           = err_q;

endmodule

// File: tb/tb_cam_cfg_cmd_sequencer.sv
// Directed bench for cam_cfg_cmd_sequencer: config/crop bursts, retry, timeout abort,
// bad address, back-to-back requests and mid-burst reset.
module tb_cam_cfg_cmd_sequencer;

    localparam int ACK_TMO    = 1023;
    localparam int WAIT_LIMIT = 2000;
    localparam int RB_ECHO = 0, RB_BAD = 1, RB_NONE = 2, RB_EDGE = 3;

    logic         sysClk = 1'b0;
    logic         rst_n;
    logic [7:0]   reg_addr;
    logic [127:0] reg_data;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   cam_i2c_addr;
    logic [15:0]  cam_i2c_data;
    logic         cam_i2c_valid;
    logic         cam_i2c_ready;
    logic [15:0]  slave_copy;
    logic         slave_copy_valid;
    logic [0:0]   cam_id;
    logic [1:0]   rgb;
    logic [3:0]   compression;
    logic         busy;
    logic         done;
    logic         err;

    int n_vec = 0;
    int n_err = 0;
    int n_hs  = 0;
    logic [23:0] exp_q[$];

    cam_cfg_cmd_sequencer dut (
        .sysClk           (sysClk),
        .rst_n            (rst_n),
        .reg_addr         (reg_addr),
        .reg_data         (reg_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cam_i2c_addr     (cam_i2c_addr),
        .cam_i2c_data     (cam_i2c_data),
        .cam_i2c_valid    (cam_i2c_valid),
        .cam_i2c_ready    (cam_i2c_ready),
        .slave_copy       (slave_copy),
        .slave_copy_valid (slave_copy_valid),
        .cam_id           (cam_id),
        .rgb              (rgb),
        .compression      (compression),
        .busy             (busy),
        .done             (done),
        .err              (err)
    );

    // clock / reset
    always #5 sysClk = ~sysClk;

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    // I2C write-handshake counter
    always @(posedge sysClk) if (cam_i2c_valid && cam_i2c_ready) n_hs <= n_hs + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks; all are entered and left at a falling edge
    task automatic send_req(input logic [7:0] a, input logic [127:0] d);
        reg_addr = a;
        reg_data = d;
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1'b1);
        @(negedge sysClk);
        in_valid = 1'b0;
    endtask

    task automatic serve_write(input int mode, output int waited);
        logic [23:0] e;
        waited = 0;
        while (!cam_i2c_valid && waited < WAIT_LIMIT) begin
            @(negedge sysClk);
            waited++;
        end
        check("i2c_valid_seen", cam_i2c_valid, 1'b1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
        check("i2c_addr", cam_i2c_addr, e[23:16]);
        check("i2c_data", cam_i2c_data, e[15:0]);
        if (cam_i2c_valid) begin
            @(negedge sysClk);
            if (mode == RB_EDGE) repeat (ACK_TMO - 1) @(negedge sysClk);
            if (mode != RB_NONE) begin
                slave_copy       = (mode == RB_BAD) ? (e[15:0] ^ 16'h0001) : e[15:0];
                slave_copy_valid = 1'b1;
                @(negedge sysClk);
                slave_copy_valid = 1'b0;
            end
        end
    endtask

    task automatic finish_check(input logic exp_err);
        check("done_pulse", done, 1'b1);
        check("err_at_done", err, exp_err);
        @(negedge sysClk);
        check("done_one_cycle", done, 1'b0);
        check("in_ready_back", in_ready, 1'b1);
    endtask

    initial begin
        int w;
        int hs0;
        logic [127:0] d;

        rst_n = 1'b0;
        reg_addr = '0;
        reg_data = '0;
        in_valid = 1'b0;
        cam_i2c_ready = 1'b1;
        slave_copy = '0;
        slave_copy_valid = 1'b0;
        repeat (2) @(negedge sysClk);
        rst_n = 1'b1;
        @(negedge sysClk);

        // reset state
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_valid", cam_i2c_valid, 1'b0);
        check("rst_addr", cam_i2c_addr, 8'h00);
        check("rst_data", cam_i2c_data, 16'h0000);
        check("rst_cam_id", cam_id, 1'b0);
        check("rst_rgb", rgb, 2'b00);
        check("rst_comp", compression, 4'b0000);
        check("rst_busy_done_err", {busy, done, err}, 3'b000);

        // 1: config cam1
        hs0 = n_hs;
        exp_q.push_back({8'h10, 16'h0040});
        exp_q.push_back({8'h11, 16'h0200});
        send_req(8'h03, 128'({2'b10, 1'b1, 16'h0200, 16'h0040}));
        check("t1_busy", busy, 1'b1);
        check("t1_cam_id", cam_id, 1'b1);
        serve_write(RB_ECHO, w);
        check("t1_latency", w, 1);
        serve_write(RB_ECHO, w);
        check("t1_step1_wait", w, 1);
        finish_check(1'b0);
        check("t1_rgb", rgb, 2'b10);
        check("t1_comp", compression, 4'b1000);
        check("t1_writes", n_hs - hs0, 2);

        // 2: crop cam0, with a stray readback while not waiting
        hs0 = n_hs;
        exp_q.push_back({8'h20, 16'h1111});
        exp_q.push_back({8'h21, 16'h2222});
        exp_q.push_back({8'h22, 16'h3333});
        exp_q.push_back({8'h23, 16'h4444});
        send_req(8'h04, {64'hDEAD_BEEF_CAFE_F00D, 64'h4444_3333_2222_1111});
        slave_copy       = 16'hBEEF;
        slave_copy_valid = 1'b1;
        @(negedge sysClk);
        slave_copy_valid = 1'b0;
        serve_write(RB_ECHO, w);
        check("t2_first_wait", w, 0);
        for (int i = 0; i < 3; i++) serve_write(RB_ECHO, w);
        finish_check(1'b0);
        check("t2_cam_id", cam_id, 1'b0);
        check("t2_rgb", rgb, 2'b10);
        check("t2_comp", compression, 4'b1000);
        check("t2_writes", n_hs - hs0, 4);

        // 3: config cam0, one mismatch, last readback lands on the timeout cycle
        hs0 = n_hs;
        d = {128{1'b1}};
        d[34:0] = {2'b01, 1'b1, 16'h0ABC, 16'h1234};
        exp_q.push_back({8'h10, 16'h1234});
        exp_q.push_back({8'h10, 16'h1234});
        exp_q.push_back({8'h11, 16'h0ABC});
        send_req(8'h02, d);
        serve_write(RB_BAD, w);
        serve_write(RB_ECHO, w);
        check("t3_reissue_wait", w, 0);
        serve_write(RB_EDGE, w);
        finish_check(1'b0);
        check("t3_rgb", rgb, 2'b11);
        check("t3_comp", compression, 4'b1001);
        check("t3_writes", n_hs - hs0, 3);

        // 4: no readback ever -> MAX_RETRY+1 issues of step 0, then abort
        hs0 = n_hs;
        for (int i = 0; i < 4; i++) exp_q.push_back({8'h10, 16'h0055});
        send_req(8'h03, 128'({2'b11, 1'b0, 16'h0066, 16'h0055}));
        serve_write(RB_NONE, w);
        for (int i = 0; i < 3; i++) begin
            serve_write(RB_NONE, w);
            check("t4_retry_gap", w, ACK_TMO);
        end
        w = 0;
        while (!done && w < WAIT_LIMIT) begin
            @(negedge sysClk);
            w++;
        end
        check("t4_abort_gap", w, ACK_TMO);
        finish_check(1'b1);
        check("t4_err_sticky", err, 1'b1);
        check("t4_rgb_kept", rgb, 2'b11);
        check("t4_comp_kept", compression, 4'b1001);
        check("t4_writes", n_hs - hs0, 4);

        // 5: bad address with a second request held behind it
        hs0 = n_hs;
        reg_addr = 8'h7F;
        reg_data = '0;
        in_valid = 1'b1;
        @(negedge sysClk);
        check("t5_done", done, 1'b1);
        check("t5_err", err, 1'b1);
        check("t5_in_ready_held", in_ready, 1'b0);
        check("t5_no_valid", cam_i2c_valid, 1'b0);
        reg_addr = 8'h02;
        reg_data = 128'({2'b00, 1'b0, 16'h0002, 16'h0001});
        exp_q.push_back({8'h10, 16'h0001});
        exp_q.push_back({8'h11, 16'h0002});
        @(negedge sysClk);
        check("t5_done_low", done, 1'b0);
        check("t5_err_sticky", err, 1'b1);
        check("t5_in_ready_idle", in_ready, 1'b1);
        @(negedge sysClk);
        in_valid = 1'b0;
        check("t5_err_cleared", err, 1'b0);
        check("t5_second_busy", busy, 1'b1);
        serve_write(RB_ECHO, w);
        serve_write(RB_ECHO, w);
        finish_check(1'b0);
        check("t5_rgb", rgb, 2'b10);
        check("t5_comp", compression, 4'b1000);
        check("t5_writes", n_hs - hs0, 2);

        // 6: reset while ISSUE is stalled
        hs0 = n_hs;
        cam_i2c_ready = 1'b0;
        send_req(8'h05, 128'(64'h0008_0007_0006_0005));
        w = 0;
        while (!cam_i2c_valid && w < WAIT_LIMIT) begin
            @(negedge sysClk);
            w++;
        end
        check("t6_issue", {cam_i2c_valid, cam_i2c_addr, cam_i2c_data}, {1'b1, 8'h20, 16'h0005});
        check("t6_cam_id", cam_id, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_in_ready", in_ready, 1'b1);
        check("t6_valid", cam_i2c_valid, 1'b0);
        check("t6_addr_data", {cam_i2c_addr, cam_i2c_data}, 24'h000000);
        check("t6_cam_id_rst", cam_id, 1'b0);
        check("t6_rgb_comp", {rgb, compression}, 6'b000000);
        check("t6_busy_done_err", {busy, done, err}, 3'b000);
        @(negedge sysClk);
        rst_n = 1'b1;
        cam_i2c_ready = 1'b1;
        check("t6_writes", n_hs - hs0, 0);
        hs0 = n_hs;
        exp_q.push_back({8'h10, 16'h0040});
        exp_q.push_back({8'h11, 16'h0200});
        send_req(8'h03, 128'({2'b10, 1'b1, 16'h0200, 16'h0040}));
        serve_write(RB_ECHO, w);
        check("t6_latency", w, 1);
        serve_write(RB_ECHO, w);
        finish_check(1'b0);
        check("t6_rgb", rgb, 2'b10);
        check("t6_comp", compression, 4'b1000);
        check("t6_writes_after", n_hs - hs0, 2);
        check("exp_q_drained", exp_q.size(), 0);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
